// File: rtl/intra_top_fetch.sv
// Top-row reference fetcher for intra prediction: streams 32 neighbour words
// per LCU from a line SRAM and accepts bottom-row writebacks on a second port.
module intra_top_fetch #(
    parameter int         PIC_LCU_W = 30,
    parameter int         LCU_WORDS = 16,
    parameter logic [7:0] DEF_PIX   = 8'd128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [4:0]  lcu_x_i,
    input  logic [6:0]  lcu_y_i,
    output logic        busy_o,
    output logic        err_o,
    output logic        ref_valid_o,
    output logic [4:0]  ref_idx_o,
    output logic [31:0] ref_data_o,
    output logic        done_o,
    input  logic        wr_valid_i,
    input  logic [4:0]  wr_lcu_x_i,
    input  logic [3:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ready_o,
    output logic        cena_o,
    output logic        oena_o,
    output logic        wena_o,
    output logic [8:0]  addra_o,
    output logic [31:0] dataa_o,
    output logic        cenb_o,
    output logic        oenb_o,
    output logic        wenb_o,
    output logic [8:0]  addrb_o,
    input  logic [31:0] datab_i
);

    typedef enum logic [1:0] {IDLE, RD, FIN} state_e;
    typedef enum logic [1:0] {SEL_RAM, SEL_DEF, SEL_REP} sel_e;

    localparam logic [5:0] PIC_W6  = 6'(PIC_LCU_W);
    localparam logic [5:0] LAST_X6 = 6'(PIC_LCU_W - 1);
    localparam logic [4:0] LW5     = 5'(LCU_WORDS);
    localparam logic [8:0] LW9     = 9'(LCU_WORDS);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  lcu_x_q, lcu_x_d;
    logic [6:0]  lcu_y_q, lcu_y_d;
    logic        err_q, err_d;
    logic        pv_q, pv_d;
    logic [4:0]  pidx_q, pidx_d;
    sel_e        psel_q, psel_d;
    logic [31:0] w15_q, w15_d;
    logic        cena_q, cena_d;
    logic [8:0]  addra_q, addra_d;
    logic [31:0] dataa_q, dataa_d;

    logic busy, start_bad, top_ok, is_last, hi, rd_acc;
    logic wr_hit, wr_go;

    assign busy      = (state_q != IDLE);
    assign start_bad = start_i && (busy || ({1'b0, lcu_x_i} >= PIC_W6));
    assign top_ok    = (lcu_y_q != 7'd0);
    assign is_last   = ({1'b0, lcu_x_q} == LAST_X6);
    assign hi        = (cnt_q >= LW5);
    assign rd_acc    = (state_q == RD) && top_ok && (!hi || !is_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lcu_x_d = lcu_x_q;
        lcu_y_d = lcu_y_q;
        pv_d    = 1'b0;
        pidx_d  = pidx_q;
        psel_d  = psel_q;
        err_d   = start_bad;
        unique case (state_q)
            IDLE: begin
                if (start_i && !start_bad) begin
                    state_d = RD;
                    cnt_d   = 5'd0;
                    lcu_x_d = lcu_x_i;
                    lcu_y_d = lcu_y_i;
                end
            end
            RD: begin
                pv_d   = 1'b1;
                pidx_d = cnt_q;
                if (!top_ok)          psel_d = SEL_DEF;
                else if (hi && is_last) psel_d = SEL_REP;
                else                  psel_d = SEL_RAM;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Right picture edge: replicate the last pixel of word 15 as top-right.
    always_comb begin
        w15_d = w15_q;
        if (pv_q && (pidx_q == LW5 - 5'd1) && (psel_q == SEL_RAM))
            w15_d = datab_i;
    end

    assign wr_hit = busy && ((wr_lcu_x_i == lcu_x_q) ||
                    ({1'b0, wr_lcu_x_i} == {1'b0, lcu_x_q} + 6'd1));
    assign wr_go  = wr_valid_i && !wr_hit && ({1'b0, wr_lcu_x_i} < PIC_W6);

    always_comb begin
        cena_d  = !wr_go;
        addra_d = addra_q;
        dataa_d = dataa_q;
        if (wr_go) begin
            addra_d = {4'd0, wr_lcu_x_i} * LW9 + {5'd0, wr_idx_i};
            dataa_d = wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            lcu_x_q <= 5'd0;
            lcu_y_q <= 7'd0;
            err_q   <= 1'b0;
            pv_q    <= 1'b0;
            pidx_q  <= 5'd0;
            psel_q  <= SEL_RAM;
            w15_q   <= 32'd0;
            cena_q  <= 1'b1;
            addra_q <= 9'd0;
            dataa_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lcu_x_q <= lcu_x_d;
            lcu_y_q <= lcu_y_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            psel_q  <= psel_d;
            w15_q   <= w15_d;
            cena_q  <= cena_d;
            addra_q <= addra_d;
            dataa_q <= dataa_d;
        end
    end

    always_comb begin
        ref_data_o = 32'd0;
        if (pv_q) begin
            unique case (psel_q)
                SEL_RAM: ref_data_o = datab_i;
                SEL_DEF: ref_data_o = {4{DEF_PIX}};
                SEL_REP: ref_data_o = {4{w15_q[31:24]}};
                default: ref_data_o = 32'd0;
            endcase
        end
    end

    assign busy_o      = busy;
    assign err_o       = err_q;
    assign ref_valid_o = pv_q;
    assign ref_idx_o   = pv_q ? pidx_q : 5'd0;
    assign done_o      = pv_q && (pidx_q == 5'd31);
    assign wr_ready_o  = !wr_hit;
    assign cena_o      = cena_q;
    assign wena_o      = cena_q;
    assign oena_o      = 1'b1;
    assign addra_o     = addra_q;
    assign dataa_o     = dataa_q;
    assign cenb_o      = !rd_acc;
    assign oenb_o      = 1'b0;
    assign wenb_o      = 1'b1;
    assign addrb_o     = rd_acc ? ({4'd0, lcu_x_q} * LW9 + {4'd0, cnt_q}) : 9'd0;

endmodule

// File: tb/tb_intra_top_fetch.sv
// Bench for intra_top_fetch: SRAM model, scoreboard of expected ref words.
module tb_intra_top_fetch;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  lcu_x_i = '0;
    logic [6:0]  lcu_y_i = '0;
    logic        busy_o, err_o, ref_valid_o, done_o;
    logic [4:0]  ref_idx_o;
    logic [31:0] ref_data_o;
    logic        wr_valid_i = 1'b0;
    logic [4:0]  wr_lcu_x_i = '0;
    logic [3:0]  wr_idx_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        wr_ready_o;
    logic        cena_o, oena_o, wena_o, cenb_o, oenb_o, wenb_o;
    logic [8:0]  addra_o, addrb_o;
    logic [31:0] dataa_o, datab_i;

    always #5 clk = ~clk;

    intra_top_fetch dut (
        .clk(clk), .rstn(rstn), .start_i(start_i),
        .lcu_x_i(lcu_x_i), .lcu_y_i(lcu_y_i),
        .busy_o(busy_o), .err_o(err_o),
        .ref_valid_o(ref_valid_o), .ref_idx_o(ref_idx_o),
        .ref_data_o(ref_data_o), .done_o(done_o),
        .wr_valid_i(wr_valid_i), .wr_lcu_x_i(wr_lcu_x_i),
        .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o),
        .cena_o(cena_o), .oena_o(oena_o), .wena_o(wena_o),
        .addra_o(addra_o), .dataa_o(dataa_o),
        .cenb_o(cenb_o), .oenb_o(oenb_o), .wenb_o(wenb_o),
        .addrb_o(addrb_o), .datab_i(datab_i)
    );

    logic [31:0] mem [512];
    logic [31:0] datab_q = '0;
    assign datab_i = datab_q;

    always @(posedge clk) begin
        if (!cenb_o) datab_q <= mem[addrb_o];
        if (!cena_o && !wena_o) mem[addra_o] <= dataa_o;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cen_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input int x, input int y,
                                          input int i);
        logic [31:0] w;
        if (y == 0) return 32'h80808080;
        if (i >= 16 && x == 29) begin
            w = mem[x*16+15];
            return {4{w[31:24]}};
        end
        return mem[x*16+i];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!cenb_o) cen_cnt++;
        if (ref_valid_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got idx %0d want none",
                         ref_idx_o);
            end else begin
                e = q.pop_front();
                chk("ref_idx", ref_idx_o, e.idx);
                chk("ref_data", ref_data_o, e.data);
                chk("ref_cycle", cyc, e.cyc);
                chk("done", done_o, e.idx == 5'd31);
                if (e.idx == 5'd31) chk("busy_at_done", busy_o, 1);
            end
        end else if (done_o) begin
            checks++;
            errors++;
            $display("FAIL stray_done: got 1 want 0");
        end
    end

    // Called at #1 after a rising edge; returns in cycle T+1.
    task automatic start_fetch(input int x, input int y);
        int t;
        t = cyc;
        start_i = 1'b1;
        lcu_x_i = 5'(x);
        lcu_y_i = 7'(y);
        cen_cnt = 0;
        for (int i = 0; i < 32; i++)
            q.push_back('{t + 2 + i, 5'(i), model(x, y, i)});
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("err_ok", err_o, 0);
        chk("busy_on", busy_o, 1);
    endtask

    task automatic wait_done(input int exp_cen);
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d words left want 0", q.size());
            q.delete();
        end
        chk("busy_off", busy_o, 0);
        chk("cen_cnt", cen_cnt, exp_cen);
    endtask

    typedef struct {
        int x;
        int y;
        bit err;
        int cen;
    } vec_t;
    vec_t vt[6];

    initial begin
        vt = '{'{1, 1, 1'b0, 32}, '{3, 0, 1'b0, 0}, '{29, 2, 1'b0, 16},
               '{30, 1, 1'b1, 0}, '{0, 5, 1'b0, 32}, '{29, 0, 1'b0, 0}};
        for (int a = 0; a < 512; a++) mem[a] = 32'(a);
        mem[479] = 32'hAABBCCDD;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_valid", ref_valid_o, 0);
        chk("rst_idx", ref_idx_o, 0);
        chk("rst_data", ref_data_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cena", cena_o, 1);
        chk("rst_wena", wena_o, 1);
        chk("rst_cenb", cenb_o, 1);
        chk("rst_addra", addra_o, 0);
        chk("rst_addrb", addrb_o, 0);
        chk("rst_dataa", dataa_o, 0);
        chk("tie_oena", oena_o, 1);
        chk("tie_oenb", oenb_o, 0);
        chk("tie_wenb", wenb_o, 1);
        rstn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            @(posedge clk);
            #1;
            if (vt[v].err) begin
                start_i = 1'b1;
                lcu_x_i = 5'(vt[v].x);
                lcu_y_i = 7'(vt[v].y);
                @(posedge clk);
                #1;
                start_i = 1'b0;
                chk("err_pulse", err_o, 1);
                chk("err_busy", busy_o, 0);
                @(posedge clk);
                #1;
                chk("err_clear", err_o, 0);
            end else begin
                start_fetch(vt[v].x, vt[v].y);
                wait_done(vt[v].cen);
            end
        end

        // start while busy
        @(posedge clk);
        #1;
        start_fetch(4, 1);
        repeat (4) @(posedge clk);
        #1;
        start_i = 1'b1;
        lcu_x_i = 5'd2;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_err", err_o, 1);
        chk("busy_err_busy", busy_o, 1);
        wait_done(32);

        // writeback blocking during fetch of x=5
        @(posedge clk);
        #1;
        start_fetch(5, 1);
        wr_valid_i = 1'b1;
        wr_lcu_x_i = 5'd5;
        wr_idx_i = 4'd0;
        wr_data_i = 32'h11111111;
        #1;
        chk("wr_blk_x5", wr_ready_o, 0);
        wr_lcu_x_i = 5'd6;
        #1;
        chk("wr_blk_x6", wr_ready_o, 0);
        wr_lcu_x_i = 5'd8;
        wr_idx_i = 4'd3;
        wr_data_i = 32'h12345678;
        #1;
        chk("wr_ok_x8", wr_ready_o, 1);
        @(posedge clk);
        #1;
        wr_valid_i = 1'b0;
        chk("wr_cena", cena_o, 0);
        chk("wr_wena", wena_o, 0);
        chk("wr_addra", addra_o, 131);
        chk("wr_dataa", dataa_o, 32'h12345678);
        @(posedge clk);
        #1;
        chk("wr_cena_1cyc", cena_o, 1);
        chk("wr_mem", mem[131], 32'h12345678);
        wr_valid_i = 1'b1;
        wr_lcu_x_i = 5'd6;
        #1;
        chk("wr_blk_x6_late", wr_ready_o, 0);
        wr_valid_i = 1'b0;
        wait_done(32);
        wr_valid_i = 1'b1;
        wr_lcu_x_i = 5'd5;
        wr_idx_i = 4'd1;
        wr_data_i = 32'h55555555;
        #1;
        chk("wr_ok_idle", wr_ready_o, 1);
        @(posedge clk);
        #1;
        wr_lcu_x_i = 5'd30;
        chk("wr_idle_addra", addra_o, 81);
        chk("wr_idle_cena", cena_o, 0);
        @(posedge clk);
        #1;
        wr_valid_i = 1'b0;
        chk("wr_drop_x30", cena_o, 1);

        // start and write to another column in the same cycle
        @(posedge clk);
        #1;
        wr_valid_i = 1'b1;
        wr_lcu_x_i = 5'd10;
        wr_idx_i = 4'd2;
        wr_data_i = 32'hCAFEF00D;
        start_fetch(0, 1);
        wr_valid_i = 1'b0;
        chk("sim_cena", cena_o, 0);
        chk("sim_addra", addra_o, 162);
        chk("sim_dataa", dataa_o, 32'hCAFEF00D);
        wait_done(32);

        // reset mid-fetch
        @(posedge clk);
        #1;
        start_fetch(1, 1);
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_valid", ref_valid_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_cenb", cenb_o, 1);
        chk("mid_rst_addrb", addrb_o, 0);
        chk("mid_rst_data", ref_data_o, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_hold", ref_valid_o, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        start_fetch(2, 3);
        wait_done(32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
